ternary_accumulator: RTL and testbench

TERNARY_ACCUMULATOR -- requirements
Module: ternary_accumulator

---
 rtl/ternary_accumulator.sv | 114 +++++++++++
 tb/tb_ternary_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ternary_accumulator.sv
// rtl/ternary_accumulator.sv - unsigned ternary accumulator with a one-entry result buffer
// Digits are 2-bit codes (00/01/10); ADD/SUB use a single-cycle generate/propagate lookahead.
module ternary_accumulator #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0]       op,
    input  logic [2*N-1:0]   b,
    output logic [2*N-1:0]   acc,
    output logic             outValid,
    input  logic             outReady,
    output logic             cOut,
    output logic             ovf,
    output logic             illegal,
    output logic [CNT_W-1:0] opCount
);
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic                accept;
    logic                subMode;
    logic                bIllegal;
    logic [2*N-1:0]      addend;
    logic [2*N-1:0]      sum;
    logic [N-1:0][2:0]   digitSum;
    logic [N-1:0]        gen;
    logic [N-1:0]        prop;
    logic [N:0]          carry;
    logic [2:0]          withCarry;

    assign inReady = ~outValid | outReady;
    assign accept  = inValid & inReady;

    // Carry into digit k from generate/propagate only, never from a neighbouring carry.
    function automatic logic carryInto(input logic [N-1:0] g, input logic [N-1:0] p,
                                       input logic cin, input int k);
        logic c;
        logic pAll;
        c    = 1'b0;
        pAll = 1'b1;
        for (int j = k - 1; j >= 0; j--) begin
            c    = c | (pAll & g[j]);
            pAll = pAll & p[j];
        end
        return c | (pAll & cin);
    endfunction

    always_comb begin
        subMode   = (op == OP_SUB);
        bIllegal  = 1'b0;
        addend    = '0;
        digitSum  = '0;
        gen       = '0;
        prop      = '0;
        carry     = '0;
        sum       = '0;
        withCarry = '0;
        for (int k = 0; k < N; k++) begin
            if (b[2*k +: 2] == 2'b11) begin
                bIllegal = 1'b1;
            end
            addend[2*k +: 2] = subMode ? (2'd2 - b[2*k +: 2]) : b[2*k +: 2];
            digitSum[k]      = {1'b0, acc[2*k +: 2]} + {1'b0, addend[2*k +: 2]};
            gen[k]           = (digitSum[k] >= 3'd3);
            prop[k]          = (digitSum[k] == 3'd2);
        end
        for (int k = 0; k <= N; k++) begin
            carry[k] = carryInto(gen, prop, subMode, k);
        end
        for (int k = 0; k < N; k++) begin
            withCarry        = digitSum[k] + {2'b00, carry[k]};
            sum[2*k +: 2]    = (withCarry >= 3'd3) ? 2'(withCarry - 3'd3) : withCarry[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cOut     <= 1'b0;
            outValid <= 1'b0;
            ovf      <= 1'b0;
            illegal  <= 1'b0;
            opCount  <= '0;
        end else if (accept) begin
            opCount  <= opCount + 1'b1;
            outValid <= 1'b1;
            if (op == OP_CLEAR) begin
                acc     <= '0;
                cOut    <= 1'b0;
                ovf     <= 1'b0;
                illegal <= 1'b0;
            end else if (bIllegal) begin
                illegal <= 1'b1;
            end else if (op == OP_LOAD) begin
                acc  <= b;
                cOut <= 1'b0;
            end else begin
                acc  <= sum;
                cOut <= carry[N];
                if ((op == OP_ADD && carry[N]) || (op == OP_SUB && !carry[N])) begin
                    ovf <= 1'b1;
                end
            end
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ternary_accumulator.sv
// tb/tb_ternary_accumulator.sv - vector table, corner sequences and random model check
module tb_ternary_accumulator;
    localparam int N  = 2;
    localparam int CW = 2;
    localparam int MODV = 9;
    localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, inValid, outReady, inReady, outValid, cOut, ovf, illegal;
    logic [1:0]    op;
    logic [2*N-1:0] b, acc;
    logic [CW-1:0] opCount;

    logic       rst1, inValid1, outReady1, inReady1, outValid1, cOut1, ovf1, illegal1;
    logic [1:0] op1, b1, acc1;
    logic [7:0] opCount1;

    ternary_accumulator #(.N(N), .CNT_W(CW)) dutA (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .op(op), .b(b),
        .acc(acc), .outValid(outValid), .outReady(outReady), .cOut(cOut), .ovf(ovf),
        .illegal(illegal), .opCount(opCount));

    ternary_accumulator #(.N(1), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst1), .inValid(inValid1), .inReady(inReady1), .op(op1), .b(b1),
        .acc(acc1), .outValid(outValid1), .outReady(outReady1), .cOut(cOut1), .ovf(ovf1),
        .illegal(illegal1), .opCount(opCount1));

    int compared = 0;
    int mismatched = 0;

    int mAcc, mCnt;
    bit mC, mOvf, mIll, mOV;

    typedef struct {
        logic [1:0] op;
        logic [3:0] b;
        logic [3:0] eAcc;
        bit         eC;
        bit         eOvf;
        bit         eIll;
        int         eCnt;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int val(input logic [3:0] x);
        return int'(x[3:2]) * 3 + int'(x[1:0]);
    endfunction

    function automatic logic [3:0] enc(input int v);
        return {2'(v / 3), 2'(v % 3)};
    endfunction

    task automatic modelReset();
        mAcc = 0; mCnt = 0; mC = 0; mOvf = 0; mIll = 0; mOV = 0;
    endtask

    task automatic modelStep(input bit r, input bit v, input logic [1:0] o,
                             input logic [3:0] bb, input bit ordy);
        bit take;
        int vb;
        take = v && (!mOV || ordy);
        vb   = val(bb);
        if (r) begin
            modelReset();
        end else if (take) begin
            mCnt = (mCnt + 1) % (1 << CW);
            mOV  = 1;
            if (o == CL) begin
                mAcc = 0; mC = 0; mOvf = 0; mIll = 0;
            end else if (bb[1:0] == 2'b11 || bb[3:2] == 2'b11) begin
                mIll = 1;
            end else if (o == LD) begin
                mAcc = vb; mC = 0;
            end else if (o == AD) begin
                mC   = (mAcc + vb) >= MODV;
                mAcc = (mAcc + vb) % MODV;
                if (mC) mOvf = 1;
            end else begin
                mC   = mAcc >= vb;
                mAcc = (mAcc - vb + MODV) % MODV;
                if (!mC) mOvf = 1;
            end
        end else if (ordy) begin
            mOV = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [1:0] o,
                         input logic [3:0] bb, input bit ordy);
        rst = r; inValid = v; op = o; b = bb; outReady = ordy;
        #1;
        chk("inReady", {31'd0, inReady}, {31'd0, (!mOV) || ordy});
        @(posedge clk);
        modelStep(r, v, o, bb, ordy);
        #1;
        chk("acc", {28'd0, acc}, {28'd0, enc(mAcc)});
        chk("cOut", {31'd0, cOut}, {31'd0, mC});
        chk("ovf", {31'd0, ovf}, {31'd0, mOvf});
        chk("illegal", {31'd0, illegal}, {31'd0, mIll});
        chk("outValid", {31'd0, outValid}, {31'd0, mOV});
        chk("opCount", {30'd0, opCount}, mCnt);
    endtask

    task automatic step1(input logic [1:0] o, input logic [1:0] bb);
        rst1 = 0; inValid1 = 1; op1 = o; b1 = bb; outReady1 = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{LD, 4'b0101, 4'b0101, 0, 0, 0, 1};
        tbl[1]  = '{AD, 4'b1010, 4'b0100, 1, 1, 0, 2};
        tbl[2]  = '{CL, 4'b1111, 4'b0000, 0, 0, 0, 3};
        tbl[3]  = '{LD, 4'b1000, 4'b1000, 0, 0, 0, 0};
        tbl[4]  = '{SB, 4'b0010, 4'b0101, 1, 0, 0, 1};
        tbl[5]  = '{SB, 4'b1010, 4'b0110, 0, 1, 0, 2};
        tbl[6]  = '{AD, 4'b0011, 4'b0110, 0, 1, 1, 3};
        tbl[7]  = '{CL, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[8]  = '{LD, 4'b0011, 4'b0000, 0, 0, 1, 1};
        tbl[9]  = '{LD, 4'b1010, 4'b1010, 0, 0, 1, 2};
        tbl[10] = '{AD, 4'b0001, 4'b0000, 1, 1, 1, 3};

        rst = 1; inValid = 0; op = LD; b = '0; outReady = 0;
        rst1 = 1; inValid1 = 0; op1 = LD; b1 = '0; outReady1 = 0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        chk("rst_acc", {28'd0, acc}, 32'd0);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_opCount", {30'd0, opCount}, 32'd0);
        chk("rst_flags", {29'd0, cOut, ovf, illegal}, 32'd0);
        chk("rst_inReady", {31'd0, inReady}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            cycle(0, 1, tbl[i].op, tbl[i].b, 1);
            chk("tbl_acc", {28'd0, acc}, {28'd0, tbl[i].eAcc});
            chk("tbl_cOut", {31'd0, cOut}, {31'd0, tbl[i].eC});
            chk("tbl_ovf", {31'd0, ovf}, {31'd0, tbl[i].eOvf});
            chk("tbl_illegal", {31'd0, illegal}, {31'd0, tbl[i].eIll});
            chk("tbl_opCount", {30'd0, opCount}, tbl[i].eCnt);
        end

        // Backpressure: second request must wait for consumption of the first.
        cycle(0, 1, CL, 4'b0000, 1);
        cycle(0, 0, LD, 4'b0000, 1);
        cycle(0, 1, LD, 4'b0001, 0);
        chk("stall_inReady", {31'd0, inReady}, 32'd0);
        cycle(0, 1, AD, 4'b0001, 0);
        chk("stall_acc", {28'd0, acc}, 32'b0001);
        cycle(0, 1, AD, 4'b0001, 1);
        chk("stall_acc2", {28'd0, acc}, 32'b0010);
        chk("stall_outValid", {31'd0, outValid}, 32'd1);

        // Reset wins over a simultaneous acceptance.
        cycle(1, 1, AD, 4'b0001, 1);
        chk("rstcol_acc", {28'd0, acc}, 32'd0);
        chk("rstcol_outValid", {31'd0, outValid}, 32'd0);
        chk("rstcol_opCount", {30'd0, opCount}, 32'd0);
        chk("rstcol_inReady", {31'd0, inReady}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] rb;
            for (int d = 0; d < 2; d++) begin
                rb[2*d +: 2] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            cycle($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom_range(0, 3)), rb,
                  1'($urandom_range(0, 3) != 0));
        end
        rst = 0; inValid = 0;

        rst1 = 0;
        for (int a = 0; a < 3; a++) begin
            for (int d = 0; d < 3; d++) begin
                step1(LD, 2'(a));
                step1(AD, 2'(d));
                chk("n1_add_acc", {30'd0, acc1}, (a + d) % 3);
                chk("n1_add_cOut", {31'd0, cOut1}, {31'd0, (a + d) >= 3});
                step1(LD, 2'(a));
                step1(SB, 2'(d));
                chk("n1_sub_acc", {30'd0, acc1}, (a - d + 3) % 3);
                chk("n1_sub_cOut", {31'd0, cOut1}, {31'd0, a >= d});
            end
        end
        inValid1 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
